dsp_mem_probe_unit: RTL and testbench

DSP_MEM_PROBE_UNIT -- requirements
Module: dsp_mem_probe_unit

---
 rtl/dsp_mem_probe_unit.sv | 120 ++++++++++++
 tb/tb_dsp_mem_probe_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dsp_mem_probe_unit.sv
// dsp_mem_probe_unit
// A 4 x 16 single-port memory with registered, write-first read.
// Alongside it sits an independent multiply-accumulate probe path:
//   - Three loadable probe-out registers A, B and C.
//   - A fixed-latency pipeline that computes p = A*B + C.
//   - A registered copy of p, delayed by one cycle.
// Memory contents are never cleared by reset. Every other register resets
// asynchronously to zero.
module dsp_mem_probe_unit #(
  parameter logic [15:0] MEM_INIT_0  = 16'h0000,
  parameter logic [15:0] MEM_INIT_1  = 16'h0000,
  parameter logic [15:0] MEM_INIT_2  = 16'h0000,
  parameter logic [15:0] MEM_INIT_3  = 16'h0000,
  // Pipeline depth from operand sample to p; meaningful range is 1..4.
  parameter int          DSP_LATENCY = 3
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        ena,
  input  logic        wea,
  input  logic [1:0]  addra,
  input  logic [15:0] dina,
  output logic [15:0] douta,
  input  logic        vio_load,
  input  logic [6:0]  vio_a_in,
  input  logic [7:0]  vio_b_in,
  input  logic [6:0]  vio_c_in,
  output logic [6:0]  probe_a,
  output logic [7:0]  probe_b,
  output logic [6:0]  probe_c,
  output logic [15:0] p,
  output logic [15:0] probe_in0
);

  // ---------------------------------------------------------------------
  // Memory
  // ---------------------------------------------------------------------
  // The contents come from the power-up image and deliberately have no
  // reset. This lets a reset leave previously written data intact.
  logic [15:0] mem [4] = '{MEM_INIT_0, MEM_INIT_1, MEM_INIT_2, MEM_INIT_3};

  // Write port: store dina when the port is enabled and writing.
  always_ff @(posedge clock_100Mhz) begin
    if (ena && wea) begin
      mem[addra] <= dina;
    end
  end

  // Registered read. On a write, the new data is forwarded (write-first).
  // The value holds while the port is disabled.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      douta <= 16'h0000;
    end else if (ena) begin
      douta <= wea ? dina : mem[addra];
    end
  end

  // ---------------------------------------------------------------------
  // Probe-out registers
  // ---------------------------------------------------------------------
  // Capture all three operands together on a load strobe; hold otherwise.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      probe_a <= 7'd0;
      probe_b <= 8'd0;
      probe_c <= 7'd0;
    end else if (vio_load) begin
      probe_a <= vio_a_in;
      probe_b <= vio_b_in;
      probe_c <= vio_c_in;
    end
  end

  // ---------------------------------------------------------------------
  // Multiply-accumulate pipeline
  // ---------------------------------------------------------------------
  // The largest possible result is 127*255+127 = 32512, so 16 bits always
  // suffice. No truncation or saturation is needed.
  logic [15:0] mac;
  assign mac = 16'(probe_a) * 16'(probe_b) + 16'(probe_c);

  // Stage 0 samples the combinational result. Each later stage is a plain
  // delay. The last stage drives p, so operands sampled at edge k appear on
  // p after edge k+DSP_LATENCY-1.
  for (genvar gi = 0; gi < DSP_LATENCY; gi++) begin : g_stage
    logic [15:0] q;
    if (gi == 0) begin : g_first
      // First stage: register the freshly computed A*B+C.
      always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
          q <= 16'h0000;
        end else begin
          q <= mac;
        end
      end
    end else begin : g_delay
      // Later stages: shift the result one stage further down the pipe.
      always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
          q <= 16'h0000;
        end else begin
          q <= g_stage[gi-1].q;
        end
      end
    end
  end

  assign p = g_stage[DSP_LATENCY-1].q;

  // Capture p every cycle for the probe input.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      probe_in0 <= 16'h0000;
    end else begin
      probe_in0 <= p;
    end
  end

endmodule

// File: tb/tb_dsp_mem_probe_unit.sv
// Directed testbench for dsp_mem_probe_unit.
// Inputs are driven just after the falling edge. Outputs are sampled at the
// falling edge, so each @(negedge) step spans exactly one rising edge.
module tb_dsp_mem_probe_unit;

  logic        clock_100Mhz = 1'b0;
  logic        reset;
  logic        ena;
  logic        wea;
  logic [1:0]  addra;
  logic [15:0] dina;
  logic [15:0] douta;
  logic        vio_load;
  logic [6:0]  vio_a_in;
  logic [7:0]  vio_b_in;
  logic [6:0]  vio_c_in;
  logic [6:0]  probe_a;
  logic [7:0]  probe_b;
  logic [6:0]  probe_c;
  logic [15:0] p;
  logic [15:0] probe_in0;

  int total = 0;
  int bad   = 0;

  always #5 clock_100Mhz = ~clock_100Mhz;

  dsp_mem_probe_unit #(
    .MEM_INIT_0 (16'h1111),
    .MEM_INIT_1 (16'hA5A5),
    .MEM_INIT_2 (16'h0002),
    .MEM_INIT_3 (16'h3333),
    .DSP_LATENCY(3)
  ) dut (
    .clock_100Mhz(clock_100Mhz),
    .reset       (reset),
    .ena         (ena),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .douta       (douta),
    .vio_load    (vio_load),
    .vio_a_in    (vio_a_in),
    .vio_b_in    (vio_b_in),
    .vio_c_in    (vio_c_in),
    .probe_a     (probe_a),
    .probe_b     (probe_b),
    .probe_c     (probe_c),
    .p           (p),
    .probe_in0   (probe_in0)
  );

  // Count one comparison and report it on a single line.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Apply one memory access and hold it across a single rising edge.
  task automatic mem_op(input logic e, input logic w, input logic [1:0] a, input logic [15:0] d);
    ena = e; wea = w; addra = a; dina = d;
    @(negedge clock_100Mhz);
    ena = 1'b0; wea = 1'b0;
  endtask

  // Load the probe-out registers on the next rising edge.
  task automatic load(input logic [6:0] a, input logic [7:0] b, input logic [6:0] c);
    vio_load = 1'b1; vio_a_in = a; vio_b_in = b; vio_c_in = c;
    @(negedge clock_100Mhz);
    vio_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ena = 1'b0; wea = 1'b0; addra = 2'd0; dina = 16'h0;
    vio_load = 1'b0; vio_a_in = 7'd0; vio_b_in = 8'd0; vio_c_in = 7'd0;
    repeat (2) @(negedge clock_100Mhz);

    // Reset state.
    check("rst_douta", 32'(douta), 32'h0);
    check("rst_probe_a", 32'(probe_a), 32'h0);
    check("rst_p", 32'(p), 32'h0);
    check("rst_probe_in0", 32'(probe_in0), 32'h0);
    reset = 1'b0;

    // Reads of the initial image.
    mem_op(1'b1, 1'b0, 2'd1, 16'h0);
    check("rd_init1", 32'(douta), 32'hA5A5);
    mem_op(1'b1, 1'b0, 2'd0, 16'h0);
    check("rd_init0", 32'(douta), 32'h1111);

    // Write-first on addr 2, then read back.
    mem_op(1'b1, 1'b1, 2'd2, 16'h1234);
    check("wr_first", 32'(douta), 32'h1234);
    mem_op(1'b1, 1'b0, 2'd1, 16'h0);
    check("rd_addr1", 32'(douta), 32'hA5A5);
    mem_op(1'b1, 1'b0, 2'd2, 16'h0);
    check("rd_addr2", 32'(douta), 32'h1234);

    // A disabled port ignores wea and holds douta.
    mem_op(1'b1, 1'b0, 2'd3, 16'h0);
    check("rd_addr3", 32'(douta), 32'h3333);
    mem_op(1'b0, 1'b1, 2'd2, 16'hFFFF);
    check("ena0_hold", 32'(douta), 32'h3333);
    mem_op(1'b1, 1'b0, 2'd2, 16'h0);
    check("ena0_nowrite", 32'(douta), 32'h1234);

    // 3*4+5 = 17, issued together with a memory write to show independence.
    ena = 1'b1; wea = 1'b1; addra = 2'd0; dina = 16'h5555;
    load(7'd3, 8'd4, 7'd5);
    ena = 1'b0; wea = 1'b0;
    check("load_probe_a", 32'(probe_a), 32'd3);
    check("load_probe_b", 32'(probe_b), 32'd4);
    check("load_probe_c", 32'(probe_c), 32'd5);
    check("par_douta", 32'(douta), 32'h5555);
    @(negedge clock_100Mhz);
    check("lat_p_e1", 32'(p), 32'd0);
    @(negedge clock_100Mhz);
    check("lat_p_e2", 32'(p), 32'd0);
    @(negedge clock_100Mhz);
    check("mac_17", 32'(p), 32'd17);
    check("pin0_lag", 32'(probe_in0), 32'd0);
    @(negedge clock_100Mhz);
    check("pin0_17", 32'(probe_in0), 32'd17);

    // Largest possible result.
    load(7'd127, 8'd255, 7'd127);
    repeat (3) @(negedge clock_100Mhz);
    check("mac_max", 32'(p), 32'h7F00);

    // Back-to-back loads produce back-to-back results.
    load(7'd1, 8'd1, 7'd0);
    load(7'd2, 8'd2, 7'd0);
    load(7'd3, 8'd3, 7'd0);
    @(negedge clock_100Mhz);
    check("b2b_1", 32'(p), 32'd1);
    @(negedge clock_100Mhz);
    check("b2b_4", 32'(p), 32'd4);
    @(negedge clock_100Mhz);
    check("b2b_9", 32'(p), 32'd9);

    // Mid-pipeline asynchronous reset while 10*10+10 is in flight.
    mem_op(1'b1, 1'b0, 2'd3, 16'h0);
    load(7'd10, 8'd10, 7'd10);
    @(posedge clock_100Mhz);
    #2 reset = 1'b1;
    #1;
    check("arst_douta", 32'(douta), 32'h0);
    check("arst_probe_b", 32'(probe_b), 32'h0);
    check("arst_p", 32'(p), 32'h0);
    check("arst_probe_in0", 32'(probe_in0), 32'h0);
    @(negedge clock_100Mhz);

    // Release, with a load on the very first edge after release.
    reset = 1'b0;
    load(7'd2, 8'd3, 7'd4);
    check("post_rst_load", 32'(probe_a), 32'd2);
    @(negedge clock_100Mhz);
    check("flush_e1", 32'(p), 32'd0);
    @(negedge clock_100Mhz);
    check("flush_e2", 32'(p), 32'd0);
    @(negedge clock_100Mhz);
    check("post_rst_mac", 32'(p), 32'd10);

    // Memory survived the reset.
    mem_op(1'b1, 1'b0, 2'd2, 16'h0);
    check("keep_addr2", 32'(douta), 32'h1234);
    mem_op(1'b1, 1'b0, 2'd0, 16'h0);
    check("keep_addr0", 32'(douta), 32'h5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
